tl_peri_regslave: RTL and testbench
===================================

Name: tl_peri_regslave

Overview:
- TileLink-UL responder (slave) for the 24 MHz peripheral domain. It is the far end of the peripheral crossbar's slave-side A/D ports.
- Decodes Get / PutFullData / PutPartialData against a small bank of 32-bit registers and returns AccessAck / AccessAckData on channel D after a programmable latency.
- One outstanding transaction at a time. Used as the default peripheral target and as a bench responder.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed 32 for this block)
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3, a_size/d_size width
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- BASE_ADDR, 32'h1000_0000, first register byte address
- NUM_REGS, 8, number of 32-bit registers (power of 2, 2..256)
- RESP_LATENCY, 2, extra wait cycles before d_valid (0..255)
- ID_VALUE, 32'h7E1E_0001, read-only contents of register 0

Ports:
- clk  in  1  24 MHz clock
- reset  in  1  synchronous, active-low reset (0 = in reset)
- a_valid  in  1  channel A valid
- a_ready  out  1  channel A ready
- a_opcode  in  OPCODE_WIDTH  0=PutFull, 1=PutPartial, 4=Get
- a_param  in  PARAM_WIDTH  ignored
- a_size  in  SIZE_WIDTH  log2 bytes
- a_source  in  1  requester ID
- a_address  in  ADDR_WIDTH  byte address
- a_mask  in  MASK_WIDTH  byte lanes
- a_data  in  DATA_WIDTH  write data
- d_valid  out  1  channel D valid
- d_ready  in  1  channel D ready
- d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
- d_param  out  PARAM_WIDTH  always 0
- d_size  out  SIZE_WIDTH  echoed a_size
- d_source  out  1  echoed a_source
- d_sink  out  1  always 0
- d_data  out  DATA_WIDTH  read data, 0 for writes and errors
- d_error  out  1  denied/corrupt response

Behaviour:
- FSM states: IDLE, WAIT, RESP.
  - Reset (reset==0 at an edge) forces IDLE, clears the latency counter, and zeroes registers 1..NUM_REGS-1.
  - Reset also clears d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data and d_error to 0.
- a_ready = (state==IDLE) && reset. It is 0 while reset is low.
- Accept: a_valid && a_ready sampled at edge k. At that edge the block:
  - captures source, size and the response opcode (Get→1, otherwise 0);
  - performs decode;
  - commits any write;
  - captures read data.
- Timing after accept:
  - If RESP_LATENCY==0, go to RESP; d_valid=1 from edge k+1.
  - Otherwise go to WAIT with the counter loaded to RESP_LATENCY-1. The counter decrements each cycle; at 0, go to RESP. d_valid=1 from edge k+1+RESP_LATENCY.
- RESP: d_valid held 1. All d_* outputs stay stable until d_ready. On d_valid && d_ready go to IDLE and drop d_valid. a_ready returns the next cycle (one-cycle bubble; no back-to-back acceptance).
- Decode, with offset = a_address - BASE_ADDR. The request is an error if any of the following holds:
  - a_address < BASE_ADDR, or offset >= NUM_REGS*4;
  - opcode is not in {0,1,4};
  - a_size > 2;
  - a_address is not aligned to 2^a_size.
- Register index = offset[log2(NUM_REGS)+1:2].
- Error response: no register change, d_data=0, d_error=1, d_opcode per the captured rule. Unsupported opcodes get AccessAck.
- Write: for each byte lane i with a_mask[i]=1, reg[idx][8i+7:8i] = a_data byte i. PutFull and PutPartial are treated identically.
- Register 0 is read-only ID_VALUE. Writes to it are silently dropped with no error.
- Read: d_data = reg[idx] value before any same-edge write (no write occurs on a Get anyway). The full word is returned regardless of a_size or a_mask.
- a_param is ignored; d_param=0; d_sink=0.
- Reset mid-operation (WAIT or RESP):
  - the pending response is discarded and d_valid is 0 after the reset edge;
  - a write that was already committed is cleared by the reset itself.
- a_valid with a_ready=0 has no effect. The requester holds the request until accepted.

Test Plan:
- Reset, then Get 0x1000_0000, size 2, source 1, RESP_LATENCY=2, accepted at edge k → d_valid at edge k+3; d_opcode=1, d_data=0x7E1E_0001, d_source=1, d_size=2, d_error=0.
- PutFull 0x1000_0008, data 0xDEAD_BEEF, mask 0xF → AccessAck (opcode 0, d_data 0, d_error 0). A following Get 0x1000_0008 returns 0xDEAD_BEEF.
- PutPartial 0x1000_0008, data 0x1122_3344, mask 0x5 → a following Get returns 0xDE22_BE44.
- Errors each → d_error=1, registers unchanged, read returns old value:
  - Get 0x1000_0020 (out of range) → d_opcode=1, d_data 0.
  - opcode 2 → d_opcode=0.
  - Get 0x1000_0002 size 2 (misaligned) → error.
- Backpressure: hold d_ready=0 for 5 cycles in RESP → d_* stable and a_ready=0 throughout. Raise d_ready → d_valid drops the next edge and a_ready=1 one cycle later.
- Assert reset for 1 cycle during WAIT after PutFull 0x1000_0004 = 0xAAAA_AAAA → no D response. A following Get 0x1000_0004 returns 0 and Get 0x1000_0000 returns ID_VALUE.

Source files
------------

// File: rtl/tl_peri_regslave.sv
// TileLink-UL register responder for the peripheral domain.
// Serves Get / PutFullData / PutPartialData against a small 32-bit register
// bank and answers on channel D after a fixed, parameterised latency.
// Exactly one transaction is in flight at a time.
module tl_peri_regslave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int                    NUM_REGS     = 8,
    parameter int                    RESP_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h7E1E_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int                      IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0]   SPAN       = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [7:0]              LOAD_VALUE = (RESP_LATENCY == 0) ? 8'd0 : 8'(RESP_LATENCY - 1);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK         = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA    = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [7:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic                    accept;
    logic                    is_get;
    logic                    is_put;
    logic                    addr_err;
    logic                    op_err;
    logic                    size_err;
    logic                    align_err;
    logic                    req_err;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_WIDTH-1:0]    idx;

    // a_param carries no meaning for this responder.
    logic unused_param;
    assign unused_param = ^a_param;

    assign a_ready  = (state == IDLE) && reset;
    assign accept   = a_valid && a_ready;
    assign offset   = a_address - BASE_ADDR;
    assign d_param  = '0;
    assign d_sink   = 1'b0;

    // Request decode: classify the opcode and flag range, size and alignment errors.
    // NOTE: every signal gets a value before any condition, so no path can infer a latch.
    always_comb begin
        is_get    = (a_opcode == OP_GET);
        is_put    = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
        op_err    = !(is_get || is_put);
        addr_err  = (a_address < BASE_ADDR) || (offset >= SPAN);
        size_err  = (a_size > SIZE_WIDTH'(2));
        align_err = 1'b0;
        if (a_size == SIZE_WIDTH'(1)) begin
            align_err = a_address[0];
        end else if (a_size == SIZE_WIDTH'(2)) begin
            align_err = |a_address[1:0];
        end
        req_err   = addr_err || op_err || size_err || align_err;
        idx       = offset[IDX_WIDTH+1:2];
        wr_en     = accept && is_put && !req_err && (idx != '0);
    end

    // Register bank: reset restores the ID word and clears the rest; accepted writes merge by byte lane.
    // NOTE: the bank is reset explicitly because software expects registers to read 0 after reset, so it must live in flops, not RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (a_mask[b]) begin
                    regs[idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM: capture the response at accept, count down the latency, hold D until taken.
    // NOTE: non-blocking assignments make the read capture see the register value from before this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            d_valid  <= 1'b0;
            d_opcode <= '0;
            d_size   <= '0;
            d_source <= 1'b0;
            d_data   <= '0;
            d_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_opcode <= is_get ? OP_ACK_DATA : OP_ACK;
                        d_size   <= a_size;
                        d_source <= a_source;
                        d_error  <= req_err;
                        d_data   <= (is_get && !req_err) ? regs[idx] : '0;
                        if (RESP_LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= LOAD_VALUE;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (!d_valid) begin
                        d_valid <= 1'b1;
                    end else if (d_ready) begin
                        d_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_peri_regslave.sv
// Self-checking bench for tl_peri_regslave: a transaction-level model predicts
// a_ready / D-channel behaviour every cycle; directed cases pin literal values.
module tb_tl_peri_regslave;

    localparam int          NREGS  = 8;
    localparam int          LAT    = 2;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] ID_VAL = 32'h7E1E_0001;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        src;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic        a_source = 1'b0;
    logic [31:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;

    always #5 clk = ~clk;

    tl_peri_regslave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .SIZE_WIDTH(3),
        .OPCODE_WIDTH(3), .PARAM_WIDTH(3), .BASE_ADDR(BASE), .NUM_REGS(NREGS),
        .RESP_LATENCY(LAT), .ID_VALUE(ID_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [NREGS];
    bit          m_busy = 0;
    int unsigned edge_n = 0;
    int unsigned m_acc_edge = 0;
    int unsigned m_dv_edge = 0;
    int unsigned m_accepts = 0;
    logic [2:0]  m_op;
    logic [2:0]  m_size;
    logic        m_src;
    logic [31:0] m_data;
    logic        m_err;

    function automatic bit is_error(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size);
        longint off;
        off = longint'(addr) - longint'(BASE);
        if (off < 0 || off >= NREGS * 4) return 1;
        if (!(op == 0 || op == 1 || op == 4)) return 1;
        if (size > 2) return 1;
        if ((addr % (32'd1 << size)) != 0) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        int idx;
        edge_n++;
        if (!reset) begin
            m_busy = 0;
            for (int i = 0; i < NREGS; i++) m_regs[i] = (i == 0) ? ID_VAL : 32'd0;
        end else if (m_busy) begin
            if (edge_n > m_dv_edge && d_ready) m_busy = 0;
        end else if (a_valid) begin
            m_err  = is_error(a_opcode, a_address, a_size);
            m_op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
            m_size = a_size;
            m_src  = a_source;
            m_data = 32'd0;
            if (!m_err) begin
                idx = int'((a_address - BASE) / 4);
                if (a_opcode == 3'd4) begin
                    m_data = m_regs[idx];
                end else if (idx != 0) begin
                    for (int b = 0; b < 4; b++)
                        if (a_mask[b]) m_regs[idx][8*b +: 8] = a_data[8*b +: 8];
                end
            end
            m_busy     = 1;
            m_acc_edge = edge_n;
            m_dv_edge  = edge_n + 1 + LAT;
            m_accepts++;
        end
    end

    // Compare process: outputs are checked against the model every cycle.
    always @(negedge clk) begin
        bit exp_dv;
        exp_dv = m_busy && (edge_n >= m_dv_edge);
        check("a_ready", a_ready, reset && !m_busy);
        check("d_valid", d_valid, exp_dv);
        if (exp_dv) begin
            check("d_opcode", d_opcode, m_op);
            check("d_size", d_size, m_size);
            check("d_source", d_source, m_src);
            check("d_data", d_data, m_data);
            check("d_error", d_error, m_err);
            check("d_param", d_param, 0);
            check("d_sink", d_sink, 0);
        end
    end

    // Capture of the latest DUT response, used by the literal checks.
    bit          cap_valid = 0;
    int unsigned cap_rise = 0;
    logic [2:0]  cap_op;
    logic [2:0]  cap_size;
    logic        cap_src;
    logic [31:0] cap_data;
    logic        cap_err;

    always @(negedge clk) begin
        if (reset && d_valid) begin
            if (!cap_valid) cap_rise = edge_n;
            cap_valid = 1;
            cap_op    = d_opcode;
            cap_size  = d_size;
            cap_src   = d_source;
            cap_data  = d_data;
            cap_err   = d_error;
        end
    end

    // ---------------- driver ----------------
    function automatic req_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                                input logic [3:0] mask, input logic [31:0] data, input logic src);
        req_t r;
        r.op = op; r.addr = addr; r.size = size; r.mask = mask; r.data = data; r.src = src;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and retire its response; optional backpressure hold or mid-flight reset.
    task automatic send(input req_t r, input bit rand_mode, input int hold, input bit mid_reset);
        int unsigned start;
        start     = m_accepts;
        cap_valid = 0;
        a_valid   = 1'b1;
        a_opcode  = r.op;
        a_address = r.addr;
        a_size    = r.size;
        a_mask    = r.mask;
        a_data    = r.data;
        a_source  = r.src;
        a_param   = 3'($urandom);
        for (int i = 0; i < 100 && m_accepts == start; i++) step();
        if (m_accepts == start) fail_now("accept_wait");
        a_valid = 1'b0;
        if (mid_reset) begin
            repeat ($urandom_range(0, LAT + 2)) begin
                d_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                step();
            end
            reset   = 1'b0;
            d_ready = 1'b0;
            step();
            reset = 1'b1;
        end
        if (hold > 0) begin
            d_ready = 1'b0;
            for (int i = 0; i < 50 && m_busy && edge_n < m_dv_edge; i++) step();
            for (int i = 0; i < hold; i++) begin
                check("bp_a_ready_low", a_ready, 0);
                check("bp_d_valid_high", d_valid, 1);
                step();
            end
        end
        for (int i = 0; i < 1000 && m_busy; i++) begin
            d_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                a_valid   = 1'b1;
                a_opcode  = 3'($urandom);
                a_address = $urandom;
            end else begin
                a_valid = 1'b0;
            end
            step();
        end
        a_valid = 1'b0;
        if (m_busy) fail_now("resp_wait");
        if (hold > 0) begin
            check("bp_d_valid_drop", d_valid, 0);
            check("bp_a_ready_back", a_ready, 1);
        end
        d_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        logic [31:0] addr;
        logic [2:0]  op;
        logic [2:0]  size;

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        check("rst_a_ready", a_ready, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_opcode", d_opcode, 0);
        check("rst_d_data", d_data, 0);
        check("rst_d_error", d_error, 0);
        check("rst_d_size", d_size, 0);
        check("rst_d_source", d_source, 0);
        reset = 1'b1;
        step();

        // ID read and latency
        send(mk(3'd4, 32'h1000_0000, 3'd2, 4'hF, 32'h0, 1'b1), 0, 0, 0);
        check("id_latency", cap_rise - m_acc_edge, 3);
        check("id_opcode", cap_op, 1);
        check("id_data", cap_data, 32'h7E1E_0001);
        check("id_source", cap_src, 1);
        check("id_size", cap_size, 2);
        check("id_error", cap_err, 0);

        // Full write then read back
        send(mk(3'd0, 32'h1000_0008, 3'd2, 4'hF, 32'hDEAD_BEEF, 1'b0), 0, 0, 0);
        check("putfull_opcode", cap_op, 0);
        check("putfull_data", cap_data, 0);
        check("putfull_error", cap_err, 0);
        send(mk(3'd4, 32'h1000_0008, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("rd_after_full", cap_data, 32'hDEAD_BEEF);

        // Partial write
        send(mk(3'd1, 32'h1000_0008, 3'd2, 4'h5, 32'h1122_3344, 1'b1), 0, 0, 0);
        check("model_partial", m_regs[2], 32'hDE22_BE44);
        send(mk(3'd4, 32'h1000_0008, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("rd_after_partial", cap_data, 32'hDE22_BE44);

        // Error cases
        send(mk(3'd4, 32'h1000_0020, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("oor_error", cap_err, 1);
        check("oor_opcode", cap_op, 1);
        check("oor_data", cap_data, 0);
        send(mk(3'd2, 32'h1000_0008, 3'd2, 4'hF, 32'h5555_5555, 1'b0), 0, 0, 0);
        check("badop_error", cap_err, 1);
        check("badop_opcode", cap_op, 0);
        send(mk(3'd4, 32'h1000_0002, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("misalign_error", cap_err, 1);
        check("misalign_data", cap_data, 0);
        send(mk(3'd4, 32'h1000_0008, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("rd_after_errors", cap_data, 32'hDE22_BE44);

        // Write to the ID register is dropped silently
        send(mk(3'd0, 32'h1000_0000, 3'd2, 4'hF, 32'h0BAD_0BAD, 1'b0), 0, 0, 0);
        check("id_write_error", cap_err, 0);
        send(mk(3'd4, 32'h1000_0000, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("id_after_write", cap_data, 32'h7E1E_0001);

        // Backpressure
        send(mk(3'd4, 32'h1000_0008, 3'd2, 4'hF, 32'h0, 1'b1), 0, 5, 0);
        check("bp_data", cap_data, 32'hDE22_BE44);

        // Reset during WAIT after a committed write
        cap_valid = 0;
        a_valid = 1'b1; a_opcode = 3'd0; a_address = 32'h1000_0004; a_size = 3'd2;
        a_mask = 4'hF; a_data = 32'hAAAA_AAAA; a_source = 1'b0;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        a_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (LAT + 4) step();
        check("mid_reset_no_resp", cap_valid, 0);
        send(mk(3'd4, 32'h1000_0004, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("mid_reset_reg1", cap_data, 0);
        send(mk(3'd4, 32'h1000_0000, 3'd2, 4'hF, 32'h0, 1'b0), 0, 0, 0);
        check("mid_reset_id", cap_data, 32'h7E1E_0001);

        // Randomized traffic checked by the model
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 3'd4;
                4, 5, 6:    op = 3'd0;
                7, 8:       op = 3'd1;
                default:    op = 3'($urandom);
            endcase
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       addr = BASE - 32'($urandom_range(1, 16));
                1:       addr = BASE + 32'(NREGS * 4) + 32'($urandom_range(0, 15));
                default: addr = BASE + 32'($urandom_range(0, NREGS * 4 - 1));
            endcase
            if ($urandom_range(0, 4) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            r = mk(op, addr, size, 4'($urandom), $urandom, 1'($urandom));
            send(r, 1, 0, ($urandom_range(0, 24) == 0));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
